// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole game flow controller.
//   game_state_t : sequencer state encoding, also driven out on o_state
//   SCORE_W      : width of the score bus
//   SEC_W        : width of the remaining-seconds bus
//   MS_PER_S     : ms ticks per lead-in second
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEADIN = 2'd1,
        ST_PLAY   = 2'd2,
        ST_OVER   = 2'd3
    } game_state_t;

    localparam int SCORE_W  = 8;
    localparam int SEC_W    = 5;
    localparam int MS_PER_S = 1000;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick pulses once every MS_DIV clk cycles.
//   clk, rst_n : clock, async active-low reset
//   clr        : high in the first cycle of a new sequencer state
//   tick       : one-cycle ms pulse
// The cycle carrying clr counts as count 0, so the period restarts exactly
// at the edge where the state changed and the first tick of a state lands
// MS_DIV-1 cycles after entry.
module ms_tick_gen #(
    parameter int MS_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;

    assign cnt_eff = clr ? '0 : cnt;
    assign tick    = (cnt_eff == CNT_W'(MS_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_eff + 1'b1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole game flow controller: idle, lead-in countdown, play, game over.
//   clk, rst_n       : clock, async active-low reset
//   i_start          : debounced centre-button pulse
//   i_game_over      : level from the countdown timer
//   i_guess_correct  : pulse from score evaluation
//   i_score          : current score
//   i_seconds        : remaining game seconds
//   o_restart_game   : one-cycle restart pulse on the first PLAY cycle
//   o_play_en        : high while in PLAY
//   o_mole_timeout   : one-cycle pulse when the mole window expires unhit
//   o_state          : current state
//   o_high_score     : best score since reset
//   o_new_record     : last finished game beat the high score
//   o_disp_value     : value for the seven-segment digit split
//
// state     | meaning
// ST_IDLE   | waiting for start, display shows high score
// ST_LEADIN | LEADIN_S second countdown before play, start ignored
// ST_PLAY   | game running, mole window timed, start aborts to lead-in
// ST_OVER   | game finished, final score shown, start begins a new lead-in
module game_sequencer
    import game_pkg::*;
#(
    parameter int MS_DIV      = 100000,
    parameter int LEADIN_S    = 3,
    parameter int WIN_MAX_MS  = 1500,
    parameter int WIN_MIN_MS  = 400,
    parameter int WIN_STEP_MS = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_game_over,
    input  logic               i_guess_correct,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [SEC_W-1:0]   i_seconds,
    output logic               o_restart_game,
    output logic               o_play_en,
    output logic               o_mole_timeout,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_high_score,
    output logic               o_new_record,
    output logic [7:0]         o_disp_value
);

    game_state_t state;
    logic [3:0]  leadin_cnt;
    logic [9:0]  ms_cnt;
    logic [10:0] win_cnt;
    logic [1:0]  play_cyc;
    logic        state_entry;
    logic        ms_tick;
    logic [31:0] win_prod;
    logic [10:0] win_load;

    assign o_state = state;

    ms_tick_gen #(.MS_DIV(MS_DIV)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_entry),
        .tick  (ms_tick)
    );

    // Window shrinks with score; compare before subtracting so a large
    // score saturates at the floor instead of wrapping.
    always_comb begin
        win_prod = 32'(WIN_STEP_MS) * 32'(i_score);
        if (win_prod >= 32'(WIN_MAX_MS - WIN_MIN_MS)) begin
            win_load = 11'(WIN_MIN_MS);
        end else begin
            win_load = 11'(WIN_MAX_MS) - win_prod[10:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            leadin_cnt     <= '0;
            ms_cnt         <= '0;
            win_cnt        <= '0;
            play_cyc       <= '0;
            state_entry    <= 1'b0;
            o_restart_game <= 1'b0;
            o_play_en      <= 1'b0;
            o_mole_timeout <= 1'b0;
            o_high_score   <= '0;
            o_new_record   <= 1'b0;
            o_disp_value   <= '0;
        end else begin
            state_entry    <= 1'b0;
            o_restart_game <= 1'b0;
            o_mole_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state       <= ST_LEADIN;
                        leadin_cnt  <= 4'(LEADIN_S);
                        ms_cnt      <= '0;
                        state_entry <= 1'b1;
                    end
                end

                ST_LEADIN: begin
                    if (ms_tick) begin
                        if (ms_cnt == 10'(MS_PER_S - 1)) begin
                            ms_cnt     <= '0;
                            leadin_cnt <= leadin_cnt - 4'd1;
                            if (leadin_cnt == 4'd1) begin
                                state          <= ST_PLAY;
                                state_entry    <= 1'b1;
                                o_restart_game <= 1'b1;
                                o_play_en      <= 1'b1;
                                win_cnt        <= win_load;
                                play_cyc       <= '0;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 10'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    // game_over is still the previous game's level until the
                    // restart has propagated; trust it from the 3rd cycle.
                    if (play_cyc != 2'd2) begin
                        play_cyc <= play_cyc + 2'd1;
                    end
                    if (i_game_over && (play_cyc == 2'd2)) begin
                        state       <= ST_OVER;
                        state_entry <= 1'b1;
                        o_play_en   <= 1'b0;
                        if (i_score > o_high_score) begin
                            o_high_score <= i_score;
                            o_new_record <= 1'b1;
                        end else begin
                            o_new_record <= 1'b0;
                        end
                    end else if (i_start) begin
                        state       <= ST_LEADIN;
                        leadin_cnt  <= 4'(LEADIN_S);
                        ms_cnt      <= '0;
                        state_entry <= 1'b1;
                        o_play_en   <= 1'b0;
                    end else if (i_guess_correct) begin
                        win_cnt <= win_load;
                    end else if (ms_tick) begin
                        if (win_cnt <= 11'd1) begin
                            o_mole_timeout <= 1'b1;
                            win_cnt        <= win_load;
                        end else begin
                            win_cnt <= win_cnt - 11'd1;
                        end
                    end
                end

                ST_OVER: begin
                    if (i_start) begin
                        state        <= ST_LEADIN;
                        leadin_cnt   <= 4'(LEADIN_S);
                        ms_cnt       <= '0;
                        state_entry  <= 1'b1;
                        o_new_record <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            case (state)
                ST_IDLE:   o_disp_value <= o_high_score;
                ST_LEADIN: o_disp_value <= {4'b0, leadin_cnt};
                ST_PLAY:   o_disp_value <= {3'b0, i_seconds};
                default:   o_disp_value <= i_score;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_game_over;
    logic       i_guess_correct;
    logic [7:0] i_score;
    logic [4:0] i_seconds;
    logic       o_restart_game;
    logic       o_play_en;
    logic       o_mole_timeout;
    logic [1:0] o_state;
    logic [7:0] o_high_score;
    logic       o_new_record;
    logic [7:0] o_disp_value;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sb_q[$];
    int mon_exp;

    typedef struct {
        logic [7:0] score;
        int         win_ms;
    } win_vec_t;

    typedef struct {
        logic [7:0] score;
        bit         start_too;
        logic [7:0] exp_high;
        bit         exp_rec;
    } game_vec_t;

    win_vec_t  win_tab[5];
    game_vec_t game_tab[3];

    game_sequencer #(
        .MS_DIV      (2),
        .LEADIN_S    (3),
        .WIN_MAX_MS  (1500),
        .WIN_MIN_MS  (400),
        .WIN_STEP_MS (100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_game_over     (i_game_over),
        .i_guess_correct (i_guess_correct),
        .i_score         (i_score),
        .i_seconds       (i_seconds),
        .o_restart_game  (o_restart_game),
        .o_play_en       (o_play_en),
        .o_mole_timeout  (o_mole_timeout),
        .o_state         (o_state),
        .o_high_score    (o_high_score),
        .o_new_record    (o_new_record),
        .o_disp_value    (o_disp_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output bit found);
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            step(1);
            if (o_state == s) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", o_state, s, limit);
        end
    endtask

    // Timeout scoreboard: each pulse pops the expected absolute cycle.
    always @(posedge clk) begin
        #1;
        if (o_mole_timeout === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL mole_timeout: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_exp = sb_q.pop_front();
                if (cyc != mon_exp) begin
                    failures++;
                    $display("FAIL mole_timeout: got pulse at cycle %0d expected cycle %0d", cyc, mon_exp);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        int  tp;
        int  last;
        int  e;
        bit  found;

        win_tab[0] = '{8'd10,  500};
        win_tab[1] = '{8'd11,  400};
        win_tab[2] = '{8'd9,   600};
        win_tab[3] = '{8'd255, 400};
        win_tab[4] = '{8'd3,   1200};

        game_tab[0] = '{8'd5, 1'b0, 8'd5, 1'b1};
        game_tab[1] = '{8'd7, 1'b1, 8'd7, 1'b1};
        game_tab[2] = '{8'd7, 1'b0, 8'd7, 1'b0};

        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_game_over     = 1'b0;
        i_guess_correct = 1'b0;
        i_score         = 8'd0;
        i_seconds       = 5'd0;

        // Reset state
        step(3);
        chk("rst_state",      o_state,        0);
        chk("rst_play_en",    o_play_en,      0);
        chk("rst_restart",    o_restart_game, 0);
        chk("rst_timeout",    o_mole_timeout, 0);
        chk("rst_high",       o_high_score,   0);
        chk("rst_record",     o_new_record,   0);
        chk("rst_disp",       o_disp_value,   0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // Lead-in: 3 s of 1000 ticks at 2 cycles each
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        t0 = cyc;
        chk("leadin_enter", o_state, 1);
        wait_until(t0 + 999);
        chk("leadin_disp3", o_disp_value, 3);
        wait_until(t0 + 1500);
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        chk("leadin_start_ignored", o_state, 1);
        wait_until(t0 + 2999);
        chk("leadin_disp2", o_disp_value, 2);
        wait_until(t0 + 4999);
        chk("leadin_disp1", o_disp_value, 1);
        wait_until(t0 + 5999);
        chk("leadin_last_cycle", o_state, 1);
        chk("leadin_no_restart", o_restart_game, 0);
        step(1);
        tp = cyc;
        chk("play_enter",   o_state,        2);
        chk("play_restart", o_restart_game, 1);
        chk("play_en",      o_play_en,      1);
        sb_q.push_back(tp + 3000);
        sb_q.push_back(tp + 6000);
        i_seconds = 5'd19;
        step(1);
        chk("restart_one_cycle", o_restart_game, 0);
        wait_until(tp + 100);
        chk("play_disp_seconds", o_disp_value, 19);

        // Score 20 saturates at the 400 ms floor
        wait_until(tp + 6000);
        i_score = 8'd20;
        sb_q.push_back(tp + 9000);
        sb_q.push_back(tp + 9800);
        sb_q.push_back(tp + 10600);

        // Hit on the expiry cycle suppresses the pulse and restarts the window
        wait_until(tp + 11399);
        i_guess_correct = 1'b1;
        step(1);
        i_guess_correct = 1'b0;
        sb_q.push_back(tp + 12200);
        wait_until(tp + 12201);
        last = tp + 12200;

        // Window length vs score
        for (int k = 0; k < 5; k++) begin
            wait_until(last + 1);
            i_score         = win_tab[k].score;
            i_guess_correct = 1'b1;
            step(1);
            i_guess_correct = 1'b0;
            last = last + 2 * win_tab[k].win_ms + 2;
            sb_q.push_back(last);
            wait_until(last + 1);
        end
        chk("timeouts_pending", sb_q.size(), 0);

        // Abort from PLAY
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        chk("abort_state",   o_state,        1);
        chk("abort_restart", o_restart_game, 0);
        chk("abort_play_en", o_play_en,      0);

        // Games ending with a stale game_over level held high
        for (int k = 0; k < 3; k++) begin
            i_game_over = 1'b1;
            i_score     = game_tab[k].score;
            if (k > 0) begin
                i_start = 1'b1;
                step(1);
                i_start = 1'b0;
                chk("over_restart_state", o_state,      1);
                chk("over_restart_rec",   o_new_record, 0);
            end
            wait_state(2'd2, 6100, found);
            e = cyc;
            chk("game_restart", o_restart_game, 1);
            step(1);
            chk("game_cyc1_state", o_state, 2);
            step(1);
            chk("game_cyc2_state", o_state, 2);
            if (game_tab[k].start_too) i_start = 1'b1;
            step(1);
            i_start = 1'b0;
            chk("game_over_state",   o_state,        3);
            chk("game_over_play_en", o_play_en,      0);
            chk("game_high",         o_high_score,   game_tab[k].exp_high);
            chk("game_record",       o_new_record,   game_tab[k].exp_rec);
            chk("game_over_latency", cyc - e,        3);
            step(1);
            chk("game_over_disp",    o_disp_value,   game_tab[k].score);
        end

        // Asynchronous reset in the middle of PLAY
        i_game_over = 1'b0;
        i_score     = 8'd0;
        i_start     = 1'b1;
        step(1);
        i_start = 1'b0;
        wait_state(2'd2, 6100, found);
        step(50);
        chk("pre_reset_play", o_state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state",   o_state,        0);
        chk("arst_play_en", o_play_en,      0);
        chk("arst_restart", o_restart_game, 0);
        chk("arst_timeout", o_mole_timeout, 0);
        chk("arst_high",    o_high_score,   0);
        chk("arst_record",  o_new_record,   0);
        chk("arst_disp",    o_disp_value,   0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(10);
        chk("post_rst_state", o_state,      0);
        chk("post_rst_high",  o_high_score, 0);
        chk("post_rst_disp",  o_disp_value, 0);
        chk("final_pending",  sb_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
